cdb_arb_mux: RTL and testbench
==============================

Name: cdb_arb_mux

Overview:
- Parametrised, registered N-channel arbitrated multiplexer for the common data bus (CDB) of the dynamic pipeline.
- Functional units (ALU, MUL/DIV, LSU, branch) raise result requests. The block picks one per cycle, by round-robin or fixed priority, and drives it onto a single registered broadcast port.
- Replaces fixed-select 4:1 result muxing with a valid/ready handshake, flush support and configurable width and channel count.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- DATA_W, 32, result data width.
- TAG_W, 5, reservation-station/ROB tag width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_W, $clog2(N_CH), width of source-channel index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush (mispredict/exception).
- in_valid  in  N_CH  per-channel request valid.
- in_data  in  N_CH*DATA_W  packed results, channel i at [i*DATA_W +: DATA_W].
- in_tag  in  N_CH*TAG_W  packed tags, same packing.
- in_ready  out  N_CH  per-channel accept (one-hot or zero).
- out_valid  out  1  CDB broadcast valid.
- out_data  out  DATA_W  broadcast result.
- out_tag  out  TAG_W  broadcast tag.
- out_src  out  SRC_W  index of granted channel.
- out_ready  in  1  downstream (RS/ROB) accepts the broadcast.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_tag=0, out_src=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is combinational; it is forced to 0 while rst_n=0.
- Reset takes precedence over flush and all transfers.
- can_load = ~out_valid | out_ready (output register empty or being drained this cycle).
- Grant, combinational:
  - RR mode: first valid channel searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
  - PRIO mode: lowest-index valid channel.
- in_ready[g] = can_load & ~flush & grant_valid. All other bits are 0. in_ready is at most one-hot.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_valid<=1, out_data<=in_data[g], out_tag<=in_tag[g], out_src<=g.
- Latency: exactly 1 cycle from accepted request to out_valid.
- Throughput: 1 result per cycle when out_ready=1.
- Drain without refill (out_valid & out_ready & no transfer): out_valid<=0. out_data, out_tag and out_src hold their last values.
- Stall (out_valid & ~out_ready): output register holds all fields. in_ready=0.
- Producers must hold in_valid, data and tag stable until their in_ready is seen high. The block does not latch un-granted requests.
- RR pointer:
  - After a transfer from g, rr_ptr <= (g+1) mod N_CH. The wrap from N_CH-1 goes to 0.
  - Unchanged on cycles without a transfer.
  - Unused (held at 0) in PRIO mode.
- Flush:
  - Edge with flush=1: out_valid<=0 and no transfer happens.
  - rr_ptr is unchanged.
  - out_data, out_tag and out_src hold.
- Flush and out_ready together: flush wins. The output is dropped, not broadcast.
- No valid inputs: grant_valid=0, in_ready=0. The output only drains.
- N_CH not a power of two: the pointer wraps at N_CH, never at 2^SRC_W.

Decomposition:
- Shared header (cdb_defs.vh): ARB_RR=0, ARB_PRIO=1, default CDB_DATA_W=32, CDB_TAG_W=5.
- One sub-module, rr_arbiter:
  - Parameters N_CH and MODE.
  - Inputs req[N_CH], ptr, enable.
  - Outputs one-hot grant[N_CH], grant_idx[SRC_W], grant_valid.
  - Purely combinational.
- The pointer register and the output register live in cdb_arb_mux.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with in_valid=4'b1111.
  - Required: out_valid=0, out_data=0, in_ready=0. After release, the first grant goes to ch0.
- RR fairness:
  - Stimulus: in_valid=4'b1111 held, out_ready=1, data ch i = 32'hA000_000i.
  - Required: out_src sequence 0,1,2,3,0 on consecutive cycles. out_data follows A0000000..A0000003. 1-cycle latency.
- PRIO mode:
  - Stimulus: ARB_MODE=1, in_valid=4'b1010.
  - Required: ch1 is granted every cycle while held. ch3 is granted only after ch1 drops in_valid.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1 (tag 5'd7).
  - Required: output holds tag 7 and in_ready=0. On out_ready=1 the next grant loads in the same cycle and out_valid stays 1.
- Flush:
  - Stimulus: flush=1 while out_valid=1 and in_valid[2]=1.
  - Required: next cycle out_valid=0, in_ready[2]=0 during the flush cycle, rr_ptr unchanged. Grant resumes the cycle after.
- Wrap with N_CH=3:
  - Stimulus: only ch2 valid, then only ch0 valid.
  - Required: after the ch2 transfer rr_ptr=0. ch0 is granted next cycle with out_src=2'd0.

Source files
------------

// File: rtl/cdb_arb_mux_pkg.sv
// Shared constants and helpers for the CDB arbitrated result multiplexer.
package cdb_arb_mux_pkg;

  // Arbitration modes
  localparam int unsigned ARB_RR   = 0;
  localparam int unsigned ARB_PRIO = 1;

  // Default payload widths
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_TAG_W  = 5;

  // Increment a channel index, wrapping at the channel count (not at a power of two)
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/cdb_arb_mux_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from a start pointer, or fixed
// lowest-index priority. Grant one-hot is gated by enable; the index and
// valid flag report the winner regardless of enable.
module cdb_arb_mux_rr_arbiter
  import cdb_arb_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned MODE  = ARB_RR,
  parameter int unsigned SRC_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             enable,
  output logic [N_CH-1:0]  grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             grant_valid
);

  int unsigned base_c;
  int unsigned dist_c;
  int unsigned best_c;

  // Pick the requester with the smallest circular distance from the start point
  always_comb begin
    base_c      = (MODE == ARB_PRIO) ? 32'd0 : 32'(ptr);
    dist_c      = 32'd0;
    best_c      = N_CH;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      dist_c = (j >= base_c) ? (j - base_c) : (j + N_CH - base_c);
      if (req[j] && (dist_c < best_c)) begin
        best_c      = dist_c;
        grant_idx   = SRC_W'(j);
        grant_valid = 1'b1;
      end
    end
  end

  // Expand the winning index to a one-hot grant when enabled
  always_comb begin
    grant = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      grant[j] = enable & grant_valid & (grant_idx == SRC_W'(j));
    end
  end

endmodule

// File: rtl/cdb_arb_mux.sv
// Registered N-channel arbitrated multiplexer driving the common data bus.
// One request is accepted per cycle into a single output register that is
// refilled in the same cycle it drains; flush drops the held broadcast.
module cdb_arb_mux
  import cdb_arb_mux_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = CDB_DATA_W,
  parameter int unsigned TAG_W    = CDB_TAG_W,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned SRC_W    = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH*TAG_W-1:0]  in_tag,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
);

  logic              can_load_c;
  logic              arb_en_c;
  logic              xfer_c;
  logic [N_CH-1:0]   grant_c;
  logic [SRC_W-1:0]  grant_idx_c;
  logic              grant_valid_c;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  rr_ptr_nxt_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [TAG_W-1:0]  sel_tag_c;

  // Output register is free when empty or being drained this cycle
  assign can_load_c = ~out_valid | out_ready;
  assign arb_en_c   = rst_n & can_load_c & ~flush;

  cdb_arb_mux_rr_arbiter #(
    .N_CH  (N_CH),
    .MODE  (ARB_MODE),
    .SRC_W (SRC_W)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr),
    .enable      (arb_en_c),
    .grant       (grant_c),
    .grant_idx   (grant_idx_c),
    .grant_valid (grant_valid_c)
  );

  // Grant is only ever raised on a valid request, so any ready bit is a transfer
  assign in_ready = grant_c;
  assign xfer_c   = arb_en_c & grant_valid_c;

  // Steer the granted channel's payload toward the output register
  always_comb begin
    sel_data_c = '0;
    sel_tag_c  = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (grant_idx_c == SRC_W'(j)) begin
        sel_data_c = in_data[j*DATA_W +: DATA_W];
        sel_tag_c  = in_tag[j*TAG_W +: TAG_W];
      end
    end
  end

  // Next round-robin start is one past the winner; priority mode keeps it at zero
  assign rr_ptr_nxt_c = (ARB_MODE == ARB_PRIO) ? '0
                      : SRC_W'(wrap_inc(32'(grant_idx_c), N_CH));

  // Output register and arbitration pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_c;
      out_tag   <= sel_tag_c;
      out_src   <= grant_idx_c;
      rr_ptr    <= rr_ptr_nxt_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arb_mux.sv
// Bench for cdb_arb_mux: a 4-channel round-robin, a 4-channel fixed-priority
// and a 3-channel round-robin instance run side by side against a
// behavioural model, with directed phases followed by random traffic.
module tb_cdb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, flush, out_ready;
  logic [3:0]   vld_a, vld_b;
  logic [2:0]   vld_c;
  logic [127:0] dat_a, dat_b;
  logic [95:0]  dat_c;
  logic [19:0]  tag_a, tag_b;
  logic [14:0]  tag_c;

  logic [3:0]  rdy_a, rdy_b;
  logic [2:0]  rdy_c;
  logic        ov_a, ov_b, ov_c;
  logic [31:0] od_a, od_b, od_c;
  logic [4:0]  ot_a, ot_b, ot_c;
  logic [1:0]  os_a, os_b, os_c;

  int checks = 0;
  int errors = 0;

  cdb_arb_mux #(.N_CH(4), .DATA_W(32), .TAG_W(5), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(vld_a), .in_data(dat_a),
    .in_tag(tag_a), .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
    .out_tag(ot_a), .out_src(os_a), .out_ready(out_ready));

  cdb_arb_mux #(.N_CH(4), .DATA_W(32), .TAG_W(5), .ARB_MODE(1)) u_pr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(vld_b), .in_data(dat_b),
    .in_tag(tag_b), .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
    .out_tag(ot_b), .out_src(os_b), .out_ready(out_ready));

  cdb_arb_mux #(.N_CH(3), .DATA_W(32), .TAG_W(5), .ARB_MODE(0)) u_w3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(vld_c), .in_data(dat_c),
    .in_tag(tag_c), .in_ready(rdy_c), .out_valid(ov_c), .out_data(od_c),
    .out_tag(ot_c), .out_src(os_c), .out_ready(out_ready));

  // Reference state, one entry per instance
  int          m_ov  [3];
  logic [31:0] m_od  [3];
  logic [4:0]  m_ot  [3];
  int          m_os  [3];
  int          m_ptr [3];
  bit          m_known = 1'b0;
  int          step_no = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed=%0h expected=%0h", name, step_no, obs, exp);
    end
  endtask

  // Round-robin / priority winner: scan channels starting at the pointer
  function automatic int pick(input logic [3:0] v, input int ptr, input int n, input int mode);
    int s;
    s = (mode == 1) ? 0 : ptr;
    for (int k = 0; k < n; k++) begin
      if (v[(s + k) % n]) return (s + k) % n;
    end
    return -1;
  endfunction

  task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] vc,
                      input logic rdy, input logic fl, input logic rs, input bit rnd);
    int          n, mode, g;
    logic [3:0]  v, exp_r, obs_r;
    logic        obs_v;
    logic [31:0] obs_d, gd;
    logic [4:0]  obs_t, gt;
    logic [1:0]  obs_s;
    int          nx_ov [3];
    logic [31:0] nx_od [3];
    logic [4:0]  nx_ot [3];
    int          nx_os [3];
    int          nx_ptr[3];
    string       nm;

    @(negedge clk);
    step_no++;
    rst_n = rs; flush = fl; out_ready = rdy;
    vld_a = va; vld_b = vb; vld_c = vc;
    for (int j = 0; j < 4; j++) begin
      dat_a[j*32 +: 32] = rnd ? $urandom : (32'hA000_0000 | 32'(j));
      dat_b[j*32 +: 32] = rnd ? $urandom : (32'hB000_0000 | 32'(j));
      tag_a[j*5 +: 5]   = rnd ? 5'($urandom) : 5'(4 + j);
      tag_b[j*5 +: 5]   = rnd ? 5'($urandom) : 5'(8 + j);
      if (j < 3) begin
        dat_c[j*32 +: 32] = rnd ? $urandom : (32'hC000_0000 | 32'(j));
        tag_c[j*5 +: 5]   = rnd ? 5'($urandom) : 5'(16 + j);
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin nm = "rr4"; n = 4; mode = 0; v = va; obs_r = rdy_a;
                 obs_v = ov_a; obs_d = od_a; obs_t = ot_a; obs_s = os_a; end
        1: begin nm = "pr4"; n = 4; mode = 1; v = vb; obs_r = rdy_b;
                 obs_v = ov_b; obs_d = od_b; obs_t = ot_b; obs_s = os_b; end
        default: begin nm = "rr3"; n = 3; mode = 0; v = {1'b0, vc}; obs_r = {1'b0, rdy_c};
                 obs_v = ov_c; obs_d = od_c; obs_t = ot_c; obs_s = os_c; end
      endcase
      g = -1;
      if (rs && !fl && (m_ov[i] == 0 || rdy)) g = pick(v, m_ptr[i], n, mode);
      exp_r = (g >= 0) ? 4'(1 << g) : 4'd0;
      gd = 32'd0; gt = 5'd0;
      if (g >= 0) begin
        case (i)
          0: begin gd = dat_a[g*32 +: 32]; gt = tag_a[g*5 +: 5]; end
          1: begin gd = dat_b[g*32 +: 32]; gt = tag_b[g*5 +: 5]; end
          default: begin gd = dat_c[g*32 +: 32]; gt = tag_c[g*5 +: 5]; end
        endcase
      end
      chk({nm, "_in_ready"}, 32'(obs_r), 32'(exp_r));
      if (m_known) begin
        chk({nm, "_out_valid"}, 32'(obs_v), 32'(m_ov[i]));
        chk({nm, "_out_data"},  obs_d,      m_od[i]);
        chk({nm, "_out_tag"},   32'(obs_t), 32'(m_ot[i]));
        chk({nm, "_out_src"},   32'(obs_s), 32'(m_os[i]));
      end
      nx_ov[i] = m_ov[i]; nx_od[i] = m_od[i]; nx_ot[i] = m_ot[i];
      nx_os[i] = m_os[i]; nx_ptr[i] = m_ptr[i];
      if (!rs) begin
        nx_ov[i] = 0; nx_od[i] = 32'd0; nx_ot[i] = 5'd0; nx_os[i] = 0; nx_ptr[i] = 0;
      end else if (fl) begin
        nx_ov[i] = 0;
      end else if (g >= 0) begin
        nx_ov[i] = 1; nx_od[i] = gd; nx_ot[i] = gt; nx_os[i] = g;
        if (mode == 0) nx_ptr[i] = (g + 1) % n;
      end else if (rdy) begin
        nx_ov[i] = 0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_ov[i] = nx_ov[i]; m_od[i] = nx_od[i]; m_ot[i] = nx_ot[i];
      m_os[i] = nx_os[i]; m_ptr[i] = nx_ptr[i];
    end
    if (!rs) m_known = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    vld_a = '0; vld_b = '0; vld_c = '0;
    dat_a = '0; dat_b = '0; dat_c = '0;
    tag_a = '0; tag_b = '0; tag_c = '0;
    for (int i = 0; i < 3; i++) begin
      m_ov[i] = 0; m_od[i] = 32'd0; m_ot[i] = 5'd0; m_os[i] = 0; m_ptr[i] = 0;
    end

    // Reset held two cycles with every channel requesting
    step(4'b1111, 4'b1111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);

    // Round-robin fairness with all requesting; priority sees ch1 and ch3
    for (int k = 0; k < 6; k++)
      step(4'b1111, 4'b1010, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    // ch1 drops, ch3 now wins in priority mode
    step(4'b1111, 4'b1000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 4'b1000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);

    // Load ch3 (tag 7), then stall it under backpressure
    step(4'b1000, 4'b1000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step(4'b1111, 4'b0110, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 4'b0110, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 4'b0110, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush with a valid output and ch2 requesting, then resume
    step(4'b0100, 4'b0100, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
    step(4'b0100, 4'b0100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush and drain together: flush wins
    step(4'b0001, 4'b0001, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Three-channel wrap: ch2 alone, then ch0 alone
    step(4'b0000, 4'b0000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional stalls, flushes and resets
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom), 4'($urandom), 3'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) != 0),
           1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
